// File: rtl/axi_ddr_calib_gate.sv
// axi_ddr_calib_gate: holds AW/AR/W until DDR calibration, rebases addresses, bounds outstanding bursts, drains on request; ports: clk_i/rst_i, calib_done_i/drain_req_i, s_* SoC side, m_* controller side, state/counter status.
module axi_ddr_calib_gate #(
  parameter int ADDR_WIDTH = 64,
  parameter int DDR_ADDR_WIDTH = 29,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(64'h8000_0000),
  parameter int MAX_OUTSTANDING = 16,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      calib_done_i,
  input  logic                      drain_req_i,
  input  logic [ADDR_WIDTH-1:0]     s_aw_addr_i,
  input  logic                      s_aw_valid_i,
  output logic                      s_aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]     s_ar_addr_i,
  input  logic                      s_ar_valid_i,
  output logic                      s_ar_ready_o,
  input  logic                      s_w_valid_i,
  input  logic                      s_w_last_i,
  output logic                      s_w_ready_o,
  output logic                      s_b_valid_o,
  input  logic                      s_b_ready_i,
  output logic                      s_r_valid_o,
  output logic                      s_r_last_o,
  input  logic                      s_r_ready_i,
  output logic [DDR_ADDR_WIDTH-1:0] m_aw_addr_o,
  output logic                      m_aw_valid_o,
  input  logic                      m_aw_ready_i,
  output logic [DDR_ADDR_WIDTH-1:0] m_ar_addr_o,
  output logic                      m_ar_valid_o,
  input  logic                      m_ar_ready_i,
  output logic                      m_w_valid_o,
  input  logic                      m_w_ready_i,
  input  logic                      m_b_valid_i,
  output logic                      m_b_ready_o,
  input  logic                      m_r_valid_i,
  input  logic                      m_r_last_i,
  output logic                      m_r_ready_o,
  output logic [1:0]                state_o,
  output logic                      quiesced_o,
  output logic [7:0]                wr_outstanding_o,
  output logic [7:0]                rd_outstanding_o,
  output logic [ERR_CNT_WIDTH-1:0]  addr_err_cnt_o
);
  typedef enum logic [1:0] {WAIT_CALIB = 2'd0, RUN = 2'd1, DRAIN = 2'd2, QUIESCED = 2'd3} state_t;
  localparam logic [7:0] MAX_OS = 8'(MAX_OUTSTANDING);
  state_t state, state_nx;
  logic [7:0] wr_cnt, rd_cnt;
  logic w_open;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  logic [ERR_CNT_WIDTH:0] err_sum;
  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  logic aw_oow, ar_oow, en_aw, en_ar, en_w, aw_hs, ar_hs, w_hs, b_hs, r_hs;
  assign en_aw = state == RUN && wr_cnt < MAX_OS;
  assign en_ar = state == RUN && rd_cnt < MAX_OS;
  assign en_w = state == RUN || wr_cnt != '0 || w_open;
  assign m_aw_valid_o = s_aw_valid_i & en_aw;
  assign s_aw_ready_o = m_aw_ready_i & en_aw;
  assign m_ar_valid_o = s_ar_valid_i & en_ar;
  assign s_ar_ready_o = m_ar_ready_i & en_ar;
  assign m_w_valid_o = s_w_valid_i & en_w;
  assign s_w_ready_o = m_w_ready_i & en_w;
  assign s_b_valid_o = m_b_valid_i & ~rst_i;
  assign m_b_ready_o = s_b_ready_i & ~rst_i;
  assign s_r_valid_o = m_r_valid_i & ~rst_i;
  assign m_r_ready_o = s_r_ready_i & ~rst_i;
  assign s_r_last_o = m_r_last_i;
  assign aw_hs = s_aw_valid_i & s_aw_ready_o;
  assign ar_hs = s_ar_valid_i & s_ar_ready_o;
  assign w_hs = s_w_valid_i & s_w_ready_o;
  assign b_hs = m_b_valid_i & m_b_ready_o;
  assign r_hs = m_r_valid_i & m_r_ready_o & m_r_last_i;
  assign aw_off = s_aw_addr_i - BASE_ADDR;
  assign ar_off = s_ar_addr_i - BASE_ADDR;
  assign aw_oow = s_aw_addr_i < BASE_ADDR || aw_off[ADDR_WIDTH-1:DDR_ADDR_WIDTH] != '0;
  assign ar_oow = s_ar_addr_i < BASE_ADDR || ar_off[ADDR_WIDTH-1:DDR_ADDR_WIDTH] != '0;
  assign m_aw_addr_o = aw_off[DDR_ADDR_WIDTH-1:0];
  assign m_ar_addr_o = ar_off[DDR_ADDR_WIDTH-1:0];
  assign err_sum = {1'b0, err_cnt} + (ERR_CNT_WIDTH+1)'(aw_hs & aw_oow) + (ERR_CNT_WIDTH+1)'(ar_hs & ar_oow);
  assign state_o = state;
  assign quiesced_o = state == QUIESCED;
  assign wr_outstanding_o = wr_cnt;
  assign rd_outstanding_o = rd_cnt;
  assign addr_err_cnt_o = err_cnt;
  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_CALIB: state_nx = calib_done_i && !drain_req_i ? RUN : WAIT_CALIB;
      RUN:        state_nx = drain_req_i ? DRAIN : !calib_done_i ? WAIT_CALIB : RUN;
      DRAIN:      state_nx = wr_cnt == '0 && rd_cnt == '0 && !w_open ? QUIESCED : DRAIN;
      QUIESCED:   state_nx = drain_req_i ? QUIESCED : WAIT_CALIB;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= WAIT_CALIB;
      wr_cnt <= '0;
      rd_cnt <= '0;
      w_open <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      wr_cnt <= wr_cnt + 8'(aw_hs) - 8'(b_hs);
      rd_cnt <= rd_cnt + 8'(ar_hs) - 8'(r_hs);
      w_open <= w_hs ? ~s_w_last_i : w_open;
      err_cnt <= err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
    end
endmodule

// File: doc/axi_ddr_calib_gate.md
Name: axi_ddr_calib_gate

Overview:
- Sits between the AXI clock-domain crossing and the DDR4 memory-controller AXI slave port, in the controller's UI clock domain.
- Holds all new AW/AR/W traffic until memory calibration completes.
- Rebases and truncates addresses into the controller's address window.
- Bounds outstanding reads and writes, and supports a drain/quiesce request for safe controller reset or clock switching.
- Only handshakes and addresses pass through this block; data, ID and other AXI fields are wired around it.

Parameters:
- ADDR_WIDTH, 64, SoC-side AXI address width.
- DDR_ADDR_WIDTH, 29, controller-side address width; must be < ADDR_WIDTH.
- BASE_ADDR, 64'h8000_0000, SoC address mapped to DDR address 0.
- MAX_OUTSTANDING, 16, maximum in-flight write bursts and, separately, maximum in-flight read bursts; range 1..255.
- ERR_CNT_WIDTH, 16, width of the out-of-window address counter.

Ports:
- clk_i  in  1  controller UI clock.
- rst_i  in  1  asynchronous, active-high reset.
- calib_done_i  in  1  controller init_calib_complete, already synchronous to clk_i.
- drain_req_i  in  1  level; high requests quiesce.
- s_aw_addr_i  in  ADDR_WIDTH  / s_aw_valid_i in 1 / s_aw_ready_o out 1.
- s_ar_addr_i  in  ADDR_WIDTH  / s_ar_valid_i in 1 / s_ar_ready_o out 1.
- s_w_valid_i in 1 / s_w_last_i in 1 / s_w_ready_o out 1.
- s_b_valid_o out 1 / s_b_ready_i in 1.
- s_r_valid_o out 1 / s_r_last_o out 1 / s_r_ready_i in 1.
- m_aw_addr_o  out  DDR_ADDR_WIDTH  / m_aw_valid_o out 1 / m_aw_ready_i in 1.
- m_ar_addr_o  out  DDR_ADDR_WIDTH  / m_ar_valid_o out 1 / m_ar_ready_i in 1.
- m_w_valid_o out 1 / m_w_ready_i in 1.
- m_b_valid_i in 1 / m_b_ready_o out 1.
- m_r_valid_i in 1 / m_r_last_i in 1 / m_r_ready_o out 1.
- state_o  out  2  current FSM state encoding.
- quiesced_o  out  1  high in QUIESCED state.
- wr_outstanding_o  out  8  in-flight write bursts.
- rd_outstanding_o  out  8  in-flight read bursts.
- addr_err_cnt_o  out  ERR_CNT_WIDTH  saturating count of out-of-window AW/AR handshakes.

Behaviour:
- Reset (rst_i high, asynchronous):
  - state = WAIT_CALIB (2'd0); counters = 0; addr_err_cnt = 0.
  - All *_valid_o, *_ready_o and quiesced_o are 0.
- FSM states: WAIT_CALIB=0, RUN=1, DRAIN=2, QUIESCED=3. Transitions are registered and take effect the cycle after the condition.
  - WAIT_CALIB -> RUN when calib_done_i=1 and drain_req_i=0.
  - RUN -> DRAIN when drain_req_i=1.
  - RUN -> WAIT_CALIB when calib_done_i=0 (calibration lost).
  - DRAIN -> QUIESCED when wr_outstanding=0, rd_outstanding=0, and no W burst is open (a W burst opens on its first beat and closes on the beat with last).
  - QUIESCED -> WAIT_CALIB when drain_req_i=0.
- AW/AR channels are combinational pass-through, enabled only in RUN:
  - m_ax_valid_o = s_ax_valid_i & en_ax.
  - s_ax_ready_o = m_ax_ready_i & en_ax.
  - en_ax = (state==RUN) & (outstanding < MAX_OUTSTANDING).
- W channel is enabled in RUN, and in DRAIN only while wr_outstanding>0 or a W burst is open. Otherwise it is blocked (valid and ready both 0).
- B and R channels always pass through in every state except reset, so in-flight responses always complete.
- Counters:
  - wr_outstanding +1 on an AW handshake, -1 on a B handshake; a simultaneous +1/-1 leaves it unchanged.
  - rd_outstanding +1 on an AR handshake, -1 on an R handshake with last.
  - Underflow is impossible by construction; verification asserts it never occurs.
- Address: m_addr = (s_addr - BASE_ADDR)[DDR_ADDR_WIDTH-1:0], combinational.
  - Out-of-window means s_addr < BASE_ADDR or s_addr >= BASE_ADDR + 2^DDR_ADDR_WIDTH.
  - An out-of-window request is still forwarded, truncated, and increments addr_err_cnt on the handshake.
  - An AW and AR error in the same cycle add 2. The counter saturates at all-ones.
- calib_done_i dropping mid-burst: AW/AR are blocked next cycle. W stays enabled until the open W burst and outstanding writes finish; B/R keep flowing.
- Latency: zero added cycles; no registers in the data path.

Test Plan:
- Hold calib_done_i=0 and assert s_aw_valid_i and s_ar_valid_i -> m_*_valid_o=0 and s_*_ready_o=0; raise calib_done_i -> state_o=1 one cycle later and the AW handshake completes.
- In RUN, AW addr 0x8000_1040 -> m_aw_addr_o=0x0000_1040 and addr_err_cnt_o=0. AR addr 0x7FFF_FFF0 -> m_ar_addr_o=0x1FFF_FFF0 and addr_err_cnt_o=1.
- MAX_OUTSTANDING=2: issue 3 ARs with no R -> the third AR is stalled (s_ar_ready_o=0) and rd_outstanding_o=2. Return one R with last -> the third AR is accepted in the same cycle the count drops below 2.
- Simultaneous AW handshake and B handshake with wr_outstanding=1 -> stays 1. Issue 300 out-of-window ARs with ERR_CNT_WIDTH=8 -> addr_err_cnt_o=255.
- With 2 writes and 1 read outstanding, assert drain_req_i -> new AW/AR blocked, W completes, all B/R return, then state_o=3 and quiesced_o=1. Release drain_req_i -> back to WAIT_CALIB, then RUN.
- Drop calib_done_i during a 4-beat W burst -> AW/AR blocked next cycle, all 4 W beats accepted, B delivered, state_o=0.
